// File: rtl/dst7_4x4_seq.sv
// Forward 4x4 DST-7. One 4-point DST-7 core is time-shared between a row
// pass (input rows into a transpose buffer) and a column pass (buffer
// columns out to a registered output beat).

// 4-point forward DST-7 core: y[k] = sum_j C[k][j] * x[j].
module dst7_4 (
    input  logic [3:0][8:0]  x,
    output logic [3:0][16:0] y
);
    localparam logic signed [7:0] Coef [4][4] = '{
        '{8'sd29,  8'sd55,  8'sd74,  8'sd84},
        '{8'sd74,  8'sd74,  8'sd0,  -8'sd74},
        '{8'sd84, -8'sd29, -8'sd74,  8'sd55},
        '{8'sd55, -8'sd84,  8'sd74, -8'sd29}
    };

    // Matrix-vector product; every row sum fits in 17 signed bits for 9-bit inputs.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            y[k] = '0;
            for (int j = 0; j < 4; j++) begin
                y[k] = y[k] + 17'(17'(Coef[k][j]) * 17'(signed'(x[j])));
            end
        end
    end
endmodule

module dst7_4x4_seq #(
    parameter int unsigned SHIFT1 = 3,
    parameter int unsigned SHIFT2 = 8,
    parameter int unsigned OUT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0][8:0]       in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0][OUT_W-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);
    typedef enum logic {StRow, StCol} state_e;

    // Round-half-up offsets; zero when the matching shift is zero.
    localparam int unsigned Rnd1Sh = (SHIFT1 == 0) ? 0 : SHIFT1 - 1;
    localparam int unsigned Rnd2Sh = (SHIFT2 == 0) ? 0 : SHIFT2 - 1;
    localparam logic signed [17:0] Rnd1 = (SHIFT1 == 0) ? 18'sd0 : (18'sd1 <<< Rnd1Sh);
    localparam logic signed [17:0] Rnd2 = (SHIFT2 == 0) ? 18'sd0 : (18'sd1 <<< Rnd2Sh);
    localparam logic signed [17:0] OutMax = (18'sd1 <<< (OUT_W - 1)) - 18'sd1;
    localparam logic signed [17:0] OutMin = -(18'sd1 <<< (OUT_W - 1));

    state_e                  state_q;
    logic [1:0]              row_cnt_q;
    logic [1:0]              col_cnt_q;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic [3:0][OUT_W-1:0]   out_data_q;
    logic [8:0]              buf_q [4][4];

    logic [3:0][8:0]         core_x;
    logic [3:0][16:0]        core_y;
    logic [3:0][8:0]         row_s;
    logic [3:0][OUT_W-1:0]   col_s;
    logic                    load;

    // Stage-1 scaling: round, arithmetic shift, clip to 9 bits.
    function automatic logic [8:0] scale1(input logic [16:0] y);
        logic signed [17:0] t;
        t = (18'(signed'(y)) + Rnd1) >>> SHIFT1;
        if (t > 18'sd255) begin
            scale1 = 9'h0ff;
        end else if (t < -18'sd256) begin
            scale1 = 9'h100;
        end else begin
            scale1 = t[8:0];
        end
    endfunction

    // Stage-2 scaling: round, arithmetic shift, clip to OUT_W bits.
    function automatic logic [OUT_W-1:0] scale2(input logic [16:0] y);
        logic signed [17:0] t;
        t = (18'(signed'(y)) + Rnd2) >>> SHIFT2;
        if (t > OutMax) begin
            scale2 = OutMax[OUT_W-1:0];
        end else if (t < OutMin) begin
            scale2 = OutMin[OUT_W-1:0];
        end else begin
            scale2 = t[OUT_W-1:0];
        end
    endfunction

    // Core input: the live row in ROW, a transposed buffer column in COL.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            core_x[j] = (state_q == StRow) ? in_data[j] : buf_q[j][col_cnt_q];
        end
    end

    dst7_4 u_core (
        .x (core_x),
        .y (core_y)
    );

    // Both scalings of the shared core output; the state picks which is used.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            row_s[k] = scale1(core_y[k]);
            col_s[k] = scale2(core_y[k]);
        end
    end

    assign load = (state_q == StCol) && (!out_valid_q || out_ready);

    // Transpose buffer: row r of stage-1 coefficients lands in buf_q[r].
    always_ff @(posedge clk) begin
        if (state_q == StRow && in_valid) begin
            for (int k = 0; k < 4; k++) begin
                buf_q[row_cnt_q][k] <= row_s[k];
            end
        end
    end

    // Sequencer FSM, counters and the registered output beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRow;
            row_cnt_q   <= '0;
            col_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else if (clear) begin
            state_q     <= StRow;
            row_cnt_q   <= '0;
            col_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                StRow: begin
                    if (in_valid) begin
                        row_cnt_q <= row_cnt_q + 2'd1;
                        if (row_cnt_q == 2'd3) begin
                            state_q <= StCol;
                        end
                    end
                    // A stalled final beat may still drain while rows arrive.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                end
                StCol: begin
                    if (load) begin
                        out_data_q  <= col_s;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (col_cnt_q == 2'd3);
                        col_cnt_q   <= col_cnt_q + 2'd1;
                        if (col_cnt_q == 2'd3) begin
                            state_q <= StRow;
                        end
                    end
                end
                default: state_q <= StRow;
            endcase
        end
    end

    assign in_ready  = (state_q == StRow);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == StCol) || (row_cnt_q != 2'd0) || out_valid_q;
endmodule

// File: tb/tb_dst7_4x4_seq.sv
// Bench for dst7_4x4_seq: two instances (default scaling, and SHIFT1=0 with a
// narrow output) share one stimulus stream and are checked against a
// plain-arithmetic 2D DST-7 reference model.
module tb_dst7_4x4_seq;
    typedef int blk_t [16];

    localparam int ShA1 = 3, ShA2 = 8, WA = 16;
    localparam int ShB1 = 0, ShB2 = 4, WB = 12;

    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [3:0][8:0] in_data = '0;
    logic in_ready_a, out_valid_a, out_last_a, busy_a;
    logic in_ready_b, out_valid_b, out_last_b, busy_b;
    logic [3:0][WA-1:0] out_data_a;
    logic [3:0][WB-1:0] out_data_b;

    int total = 0, bad = 0, cyc = 0;
    bit done = 0;
    int qa[$], qb[$], qc[$], exp_a[$], exp_b[$];
    bit ql[$];

    int m[4][4] = '{'{29, 55, 74, 84}, '{74, 74, 0, -74}, '{84, -29, -74, 55}, '{55, -84, 74, -29}};
    int dc_exp[16] = '{28, 9, 4, 2, 9, 3, 1, 1, 5, 1, 1, 0, 2, 1, 0, 0};

    dst7_4x4_seq u_dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_last(out_last_a), .busy(busy_a)
    );

    dst7_4x4_seq #(.SHIFT1(ShB1), .SHIFT2(ShB2), .OUT_W(WB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_last(out_last_b), .busy(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Beat monitor: records every handshake of both instances.
    always @(negedge clk) begin
        if (out_valid_a && out_ready) begin
            for (int k = 0; k < 4; k++) qa.push_back(int'($signed(out_data_a[k])));
            ql.push_back(out_last_a);
            qc.push_back(cyc);
        end
        if (out_valid_b && out_ready) begin
            for (int k = 0; k < 4; k++) qb.push_back(int'($signed(out_data_b[k])));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int scale(input int v, input int sh, input int w);
        int r, lo, hi;
        r  = (sh == 0) ? v : ((v + (1 << (sh - 1))) >>> sh);
        lo = -(1 << (w - 1));
        hi = (1 << (w - 1)) - 1;
        return (r > hi) ? hi : ((r < lo) ? lo : r);
    endfunction

    // Reference 2D transform: o[c*4+k] is coefficient k of output beat c.
    task automatic ref_2d(input blk_t b, input int s1, input int s2, input int w, output blk_t o);
        int t[16];
        int acc;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                acc = 0;
                for (int j = 0; j < 4; j++) acc += m[k][j] * b[r*4+j];
                t[r*4+k] = scale(acc, s1, 9);
            end
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++) begin
                acc = 0;
                for (int j = 0; j < 4; j++) acc += m[k][j] * t[j*4+c];
                o[c*4+k] = scale(acc, s2, w);
            end
    endtask

    task automatic model_block(input blk_t b);
        blk_t oa, ob;
        ref_2d(b, ShA1, ShA2, WA, oa);
        ref_2d(b, ShB1, ShB2, WB, ob);
        foreach (oa[i]) exp_a.push_back(oa[i]);
        foreach (ob[i]) exp_b.push_back(ob[i]);
    endtask

    task automatic fill(input int v, output blk_t b);
        foreach (b[i]) b[i] = v;
    endtask

    task automatic rand_blk(output blk_t b);
        foreach (b[i]) b[i] = int'($urandom_range(511)) - 256;
    endtask

    task automatic clear_sb();
        qa.delete(); qb.delete(); ql.delete(); qc.delete(); exp_a.delete(); exp_b.delete();
    endtask

    // Present row r and hold it until accepted; returns at posedge+1.
    task automatic push_row(input blk_t b, input int r);
        int n;
        in_valid = 1'b1;
        for (int j = 0; j < 4; j++) in_data[j] = 9'(b[r*4+j]);
        n = 0;
        @(negedge clk);
        while (!in_ready_a && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL row accept timeout: in_ready=%0b required 1", in_ready_a);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input blk_t b);
        model_block(b);
        for (int r = 0; r < 4; r++) push_row(b, r);
    endtask

    task automatic wait_beats(output bit ok);
        int n;
        n = 0;
        while ((qa.size() < exp_a.size() || qb.size() < exp_b.size()) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        ok = (n < 2000);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (out_valid_a !== 1'b0 || out_data_a !== '0 || out_last_a !== 1'b0 || busy_a !== 1'b0 ||
            in_ready_a !== 1'b1 || out_valid_b !== 1'b0 || out_data_b !== '0) begin
            bad++;
            $display("FAIL reset state: valid=%0b data=%h last=%0b busy=%0b rdy=%0b required 0/0/0/0/1",
                     out_valid_a, out_data_a, out_last_a, busy_a, in_ready_a);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_dc();
        blk_t b;
        bit ok;
        clear_sb();
        fill(1, b);
        send_block(b);
        total++;
        if (out_valid_a !== 1'b0) begin
            bad++; $display("FAIL dc latency early: out_valid=%0b required 0", out_valid_a);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid_a !== 1'b1 || out_valid_b !== 1'b1) begin
            bad++; $display("FAIL dc latency: out_valid=%0b/%0b required 1", out_valid_a, out_valid_b);
        end
        wait_beats(ok);
        total++;
        if (!ok || qa.size() != 16 || qb.size() != 16) begin
            bad++; $display("FAIL dc count: got %0d/%0d coefs required 16", qa.size(), qb.size());
        end
        for (int i = 0; i < 16 && i < qa.size() && i < qb.size(); i++) begin
            total++;
            if (qa[i] !== dc_exp[i] || qb[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL dc coef %0d: got %0d,%0d required %0d,%0d", i, qa[i], qb[i], dc_exp[i], exp_b[i]);
            end
        end
        for (int i = 0; i < ql.size(); i++) begin
            total++;
            if (ql[i] !== (i % 4 == 3)) begin
                bad++; $display("FAIL dc last beat %0d: got %0b", i, ql[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        blk_t z, d;
        bit ok;
        clear_sb();
        fill(0, z);
        fill(1, d);
        send_block(z);
        send_block(d);
        send_block(d);
        wait_beats(ok);
        total++;
        if (!ok || qa.size() != exp_a.size() || qb.size() != exp_b.size()) begin
            bad++; $display("FAIL b2b count: got %0d/%0d required %0d", qa.size(), qb.size(), exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < qa.size() && i < qb.size(); i++) begin
            total++;
            if (qa[i] !== exp_a[i] || qb[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL b2b coef %0d: got %0d,%0d required %0d,%0d", i, qa[i], qb[i], exp_a[i], exp_b[i]);
            end
        end
        for (int i = 1; i < qc.size(); i++) begin
            total++;
            if ((i % 4 != 0 && qc[i] - qc[i-1] != 1) || (i % 4 == 0 && qc[i] - qc[i-4] != 8)) begin
                bad++; $display("FAIL b2b spacing beat %0d: cycle %0d after %0d", i, qc[i], qc[i-1]);
            end
        end
    endtask

    task automatic test_saturation();
        blk_t b;
        bit ok;
        clear_sb();
        fill(255, b);
        send_block(b);
        fill(-256, b);
        send_block(b);
        foreach (b[i]) b[i] = (i % 2 == 0) ? 255 : -256;
        send_block(b);
        wait_beats(ok);
        total++;
        if (!ok || qa.size() != exp_a.size() || qb.size() != exp_b.size()) begin
            bad++; $display("FAIL sat count: got %0d/%0d required %0d", qa.size(), qb.size(), exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < qa.size() && i < qb.size(); i++) begin
            total++;
            if (qa[i] !== exp_a[i] || qb[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL sat coef %0d: got %0d,%0d required %0d,%0d", i, qa[i], qb[i], exp_a[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        blk_t b;
        bit ok;
        clear_sb();
        fill(1, b);
        send_block(b);
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                total++;
                if (out_valid_a !== 1'b1 || int'($signed(out_data_a[k])) !== exp_a[4+k] ||
                    int'($signed(out_data_b[k])) !== exp_b[4+k]) begin
                    bad++;
                    $display("FAIL bp hold c%0d k%0d: valid=%0b got %0d,%0d required %0d,%0d", n, k,
                             out_valid_a, $signed(out_data_a[k]), $signed(out_data_b[k]), exp_a[4+k], exp_b[4+k]);
                end
            end
        end
        out_ready = 1'b1;
        wait_beats(ok);
        total++;
        if (!ok || qa.size() != 16 || qb.size() != 16) begin
            bad++; $display("FAIL bp count: got %0d/%0d coefs required 16", qa.size(), qb.size());
        end
        for (int i = 0; i < 16 && i < qa.size() && i < qb.size(); i++) begin
            total++;
            if (qa[i] !== exp_a[i] || qb[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL bp coef %0d: got %0d,%0d required %0d,%0d", i, qa[i], qb[i], exp_a[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_overlap();
        blk_t a, b;
        bit ok;
        clear_sb();
        fill(1, a);
        rand_blk(b);
        send_block(a);
        repeat (4) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        model_block(b);
        for (int r = 0; r < 4; r++) begin
            total++;
            if (in_ready_a !== 1'b1 || out_valid_a !== 1'b1 || out_last_a !== 1'b1 ||
                int'($signed(out_data_a[0])) !== exp_a[12] || int'($signed(out_data_a[1])) !== exp_a[13] ||
                int'($signed(out_data_a[2])) !== exp_a[14] || int'($signed(out_data_a[3])) !== exp_a[15]) begin
                bad++;
                $display("FAIL overlap row %0d: rdy=%0b valid=%0b last=%0b data=%h", r, in_ready_a,
                         out_valid_a, out_last_a, out_data_a);
            end
            push_row(b, r);
        end
        repeat (3) @(negedge clk);
        total++;
        if (out_valid_a !== 1'b1 || out_last_a !== 1'b1 || int'($signed(out_data_a[0])) !== exp_a[12]) begin
            bad++;
            $display("FAIL overlap stall: valid=%0b last=%0b c0=%0d required 1/1/%0d", out_valid_a,
                     out_last_a, $signed(out_data_a[0]), exp_a[12]);
        end
        out_ready = 1'b1;
        wait_beats(ok);
        total++;
        if (!ok || qa.size() != 32 || qb.size() != 32) begin
            bad++; $display("FAIL overlap count: got %0d/%0d coefs required 32", qa.size(), qb.size());
        end
        for (int i = 0; i < 32 && i < qa.size() && i < qb.size(); i++) begin
            total++;
            if (qa[i] !== exp_a[i] || qb[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL overlap coef %0d: got %0d,%0d required %0d,%0d", i, qa[i], qb[i], exp_a[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        blk_t d;
        bit ok;
        clear_sb();
        fill(1, d);
        send_block(d);
        repeat (4) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        push_row(d, 0);
        push_row(d, 1);
        total++;
        if (busy_a !== 1'b1 || out_valid_a !== 1'b1) begin
            bad++; $display("FAIL rst_mid pre: busy=%0b valid=%0b required 1/1", busy_a, out_valid_a);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid_a !== 1'b0 || out_data_a !== '0 || out_last_a !== 1'b0 || busy_a !== 1'b0 ||
            out_valid_b !== 1'b0 || out_data_b !== '0 || in_ready_a !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid zero: valid=%0b data=%h last=%0b busy=%0b rdy=%0b", out_valid_a,
                     out_data_a, out_last_a, busy_a, in_ready_a);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready_a !== 1'b1 || busy_a !== 1'b0) begin
            bad++; $display("FAIL rst_mid release: rdy=%0b busy=%0b required 1/0", in_ready_a, busy_a);
        end
        clear_sb();
        send_block(d);
        wait_beats(ok);
        total++;
        if (!ok || qa.size() != 16) begin
            bad++; $display("FAIL rst_mid count: got %0d coefs required 16", qa.size());
        end
        for (int i = 0; i < 16 && i < qa.size(); i++) begin
            total++;
            if (qa[i] !== dc_exp[i]) begin
                bad++; $display("FAIL rst_mid coef %0d: got %0d required %0d", i, qa[i], dc_exp[i]);
            end
        end
    endtask

    task automatic test_clear();
        blk_t d;
        bit ok;
        clear_sb();
        fill(1, d);
        out_ready = 1'b0;
        send_block(d);
        repeat (2) begin @(posedge clk); #1; end
        total++;
        if (out_valid_a !== 1'b1 || busy_a !== 1'b1) begin
            bad++; $display("FAIL clear pre: valid=%0b busy=%0b required 1/1", out_valid_a, busy_a);
        end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        total++;
        if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0 || busy_a !== 1'b0 || in_ready_a !== 1'b1) begin
            bad++;
            $display("FAIL clear: valid=%0b/%0b busy=%0b rdy=%0b required 0/0/0/1", out_valid_a,
                     out_valid_b, busy_a, in_ready_a);
        end
        clear_sb();
        out_ready = 1'b1;
        send_block(d);
        wait_beats(ok);
        total++;
        if (!ok || qa.size() != 16 || qb.size() != 16) begin
            bad++; $display("FAIL clear count: got %0d/%0d coefs required 16", qa.size(), qb.size());
        end
        for (int i = 0; i < 16 && i < qa.size() && i < qb.size(); i++) begin
            total++;
            if (qa[i] !== dc_exp[i] || qb[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL clear coef %0d: got %0d,%0d required %0d,%0d", i, qa[i], qb[i], dc_exp[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        clear_sb();
        done = 0;
        fork
            begin
                blk_t b;
                for (int n = 0; n < 8; n++) begin
                    rand_blk(b);
                    model_block(b);
                    for (int r = 0; r < 4; r++) begin
                        repeat ($urandom_range(2)) begin @(posedge clk); #1; end
                        push_row(b, r);
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_beats(ok);
        total++;
        if (!ok || qa.size() != exp_a.size() || qb.size() != exp_b.size()) begin
            bad++; $display("FAIL rand count: got %0d/%0d required %0d", qa.size(), qb.size(), exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < qa.size() && i < qb.size(); i++) begin
            total++;
            if (qa[i] !== exp_a[i] || qb[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL rand coef %0d: got %0d,%0d required %0d,%0d", i, qa[i], qb[i], exp_a[i], exp_b[i]);
            end
        end
        for (int i = 0; i < ql.size(); i++) begin
            total++;
            if (ql[i] !== (i % 4 == 3)) begin
                bad++; $display("FAIL rand last beat %0d: got %0b", i, ql[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dc();
        test_back_to_back();
        test_saturation();
        test_backpressure();
        test_overlap();
        test_reset_mid();
        test_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
